// File: rtl/alu_pkg.sv
// Opcodes, destination select and sequencer state encoding shared by the
// 16-bit ALU and its sequencer.
package alu_pkg;

    localparam logic [3:0] OP_SHL  = 4'h0;
    localparam logic [3:0] OP_SHR  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_ZT   = 4'h7;
    localparam logic [3:0] OP_PCZ  = 4'h8;
    localparam logic [3:0] OP_PCZB = 4'h9;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam logic DEST_W = 1'b0;
    localparam logic DEST_M = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } seq_state_e;

    // Opcodes 8..F never write back: they only test flags or do nothing.
    function automatic logic is_ctrl_op(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle controller in front of the ALU: latches one instruction, runs it
// for one EXEC cycle, retires the result to W or a memory write port.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_op,
    input  logic             issue_dest,
    input  logic [WIDTH-1:0] issue_mem,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_mem,
    output logic [WIDTH-1:0] alu_wreg,
    output logic             alu_carry_in,
    output logic             alu_zero_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry_out,
    input  logic             alu_zero_out,
    input  logic             alu_skip,
    output logic [WIDTH-1:0] wreg_q,
    output logic             flag_c,
    output logic             flag_z,
    output logic             mem_wr_valid,
    input  logic             mem_wr_ready,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic             pc_skip,
    output logic             done
);

    seq_state_e       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             dest_q, dest_d;
    logic [WIDTH-1:0] mem_q, mem_d;
    logic [WIDTH-1:0] wreg_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             wr_valid_q, wr_valid_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             pc_skip_q, pc_skip_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            dest_q     <= 1'b0;
            mem_q      <= '0;
            wreg_q     <= '0;
            c_q        <= 1'b0;
            z_q        <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            pc_skip_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            mem_q      <= mem_d;
            wreg_q     <= wreg_d;
            c_q        <= c_d;
            z_q        <= z_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            pc_skip_q  <= pc_skip_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dest_d     = dest_q;
        mem_d      = mem_q;
        wreg_d     = wreg_q;
        c_d        = c_q;
        z_d        = z_q;
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        pc_skip_d  = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    op_d    = issue_op;
                    dest_d  = issue_dest;
                    mem_d   = issue_mem;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The ALU already passes flags through for ops that preserve them.
                c_d = alu_carry_out;
                z_d = alu_zero_out;
                if (is_ctrl_op(op_q)) begin
                    pc_skip_d = alu_skip && (op_q == OP_PCZ || op_q == OP_PCZB);
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else if (dest_q == DEST_W) begin
                    wreg_d  = alu_result;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wr_data_d  = alu_result;
                    wr_valid_d = 1'b1;
                    state_d    = ST_WB;
                end
            end
            ST_WB: begin
                if (mem_wr_ready) begin
                    wr_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign issue_ready  = (state_q == ST_IDLE);
    assign alu_op       = (state_q == ST_EXEC) ? op_q : OP_NOP;
    assign alu_mem      = mem_q;
    assign alu_wreg     = wreg_q;
    assign alu_carry_in = c_q;
    assign alu_zero_in  = z_q;
    assign flag_c       = c_q;
    assign flag_z       = z_q;
    assign mem_wr_valid = wr_valid_q;
    assign mem_wr_data  = wr_data_q;
    assign pc_skip      = pc_skip_q;
    assign done         = done_q;

endmodule
